// File: rtl/ssb_demodulator.sv
// SSB receive mixer: multiplies ADC samples by a square-wave quadrature LO, then
// integrate-and-dump decimation, with the I/Q result held behind a valid/ready handshake.
module ssb_demodulator #(
    parameter int NBITS = 24,
    parameter int DBITS = 16,
    parameter int ACCW  = DBITS + 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stdby,
    input  logic signed [DBITS-1:0] adc_data,
    input  logic                    adc_valid,
    input  logic [NBITS-1:0]        lo_freq,
    input  logic [15:0]             decim,
    output logic signed [ACCW-1:0]  i_out,
    output logic signed [ACCW-1:0]  q_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    logic [NBITS-1:0]       phase_reg;
    logic [15:0]            cnt_reg;
    logic                   out_valid_reg;
    logic                   overrun_reg;
    logic signed [ACCW-1:0] acc_reg [2];
    logic signed [ACCW-1:0] out_reg [2];
    logic signed [ACCW-1:0] sum_next [2];
    logic [1:0]             lo_neg;
    logic signed [ACCW-1:0] sample_ext;
    logic [15:0]            dec_last;
    logic                   accepted;
    logic                   dump;
    logic                   load;

    always_comb begin
        accepted   = adc_valid && !stdby;
        sample_ext = ACCW'(adc_data);
        // Lane 0 (I) is sine-like, lane 1 (Q) is cosine-like
        lo_neg[0]  = phase_reg[NBITS-1];
        lo_neg[1]  = phase_reg[NBITS-1] ^ phase_reg[NBITS-2];
        dec_last   = (decim == 16'd0) ? 16'd0 : decim - 16'd1;
        dump       = accepted && (cnt_reg >= dec_last);
        load       = dump && (!out_valid_reg || out_ready);
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            always_comb begin
                sum_next[gi] = acc_reg[gi] + (lo_neg[gi] ? -sample_ext : sample_ext);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg[gi] <= '0;
                    out_reg[gi] <= '0;
                end else begin
                    if (stdby || dump) begin
                        acc_reg[gi] <= '0;
                    end else if (accepted) begin
                        acc_reg[gi] <= sum_next[gi];
                    end
                    if (load) begin
                        out_reg[gi] <= sum_next[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg     <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (accepted) begin
                phase_reg <= phase_reg + lo_freq;
            end
            if (stdby || dump) begin
                cnt_reg <= '0;
            end else if (accepted) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
            if (load) begin
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // A fresh discard takes priority over a simultaneous clear
            if (dump && out_valid_reg && !out_ready) begin
                overrun_reg <= 1'b1;
            end else if (overrun_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign i_out     = out_reg[0];
    assign q_out     = out_reg[1];
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_ssb_demodulator.sv
// Bench for ssb_demodulator: directed vector table plus randomized traffic,
// every cycle compared with a phase/block-sum reference model.
module tb_ssb_demodulator;

    localparam int NBITS = 24;
    localparam int DBITS = 16;
    localparam int ACCW  = DBITS + 17;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    stdby = 1'b0;
    logic signed [DBITS-1:0] adc_data = '0;
    logic                    adc_valid = 1'b0;
    logic [NBITS-1:0]        lo_freq = '0;
    logic [15:0]             decim = 16'd1;
    logic signed [ACCW-1:0]  i_out;
    logic signed [ACCW-1:0]  q_out;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    overrun;
    logic                    overrun_clr = 1'b0;

    ssb_demodulator #(.NBITS(NBITS), .DBITS(DBITS), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst), .stdby(stdby), .adc_data(adc_data),
        .adc_valid(adc_valid), .lo_freq(lo_freq), .decim(decim),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     rst, stdby, av;
        int     data;
        int     lo;
        int     dec;
        bit     rdy, clr;
        bit     chk;
        longint ei, eq;
        bit     ev, eo;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    longint      m_phase = 0;
    longint      m_sum_i = 0, m_sum_q = 0;
    int          m_count = 0;
    longint      m_out_i = 0, m_out_q = 0;
    bit          m_valid = 0, m_ovr = 0;

    function automatic void push(bit r, bit s, bit av, int d, int lo, int dec, bit rdy, bit clr,
                                 bit chk = 0, longint ei = 0, longint eq = 0, bit ev = 0, bit eo = 0);
        vec_t v;
        v.rst = r; v.stdby = s; v.av = av; v.data = d; v.lo = lo; v.dec = dec;
        v.rdy = rdy; v.clr = clr; v.chk = chk; v.ei = ei; v.eq = eq; v.ev = ev; v.eo = eo;
        tbl.push_back(v);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    function automatic void model_edge();
        bit     dump = 0;
        longint res_i = 0, res_q = 0;
        longint quadrant;
        int     si, sq, blk;
        if (rst) begin
            m_phase = 0; m_sum_i = 0; m_sum_q = 0; m_count = 0;
            m_out_i = 0; m_out_q = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        if (stdby) begin
            m_sum_i = 0; m_sum_q = 0; m_count = 0;
        end else if (adc_valid) begin
            quadrant = m_phase / (longint'(1) << (NBITS - 2));
            si = (quadrant >= 2) ? -1 : 1;
            sq = (quadrant == 1 || quadrant == 2) ? -1 : 1;
            m_sum_i += si * longint'(adc_data);
            m_sum_q += sq * longint'(adc_data);
            m_count++;
            blk = (decim == 0) ? 1 : int'(decim);
            if (m_count >= blk) begin
                dump = 1; res_i = m_sum_i; res_q = m_sum_q;
                m_sum_i = 0; m_sum_q = 0; m_count = 0;
            end
            m_phase = (m_phase + longint'(lo_freq)) % (longint'(1) << NBITS);
        end
        if (dump && m_valid && !out_ready) begin
            m_ovr = 1;
        end else begin
            if (overrun_clr) m_ovr = 0;
            if (dump) begin
                m_out_i = res_i; m_out_q = res_q; m_valid = 1;
                $display("result: i=%0d q=%0d", res_i, res_q);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        total++;
        if (longint'(i_out) != m_out_i || longint'(q_out) != m_out_q ||
            out_valid != m_valid || overrun != m_ovr) begin
            bad++;
            $display("FAIL model: got i=%0d q=%0d v=%0b o=%0b want i=%0d q=%0d v=%0b o=%0b",
                     i_out, q_out, out_valid, overrun, m_out_i, m_out_q, m_valid, m_ovr);
        end
    endtask

    initial begin
        // Reset and DC block at phase 0
        push(1,0,0,0,0,4,0,0, 1, 0,0,0,0);
        push(0,0,1,1000,0,4,0,0);
        push(0,0,1,1000,0,4,0,0);
        push(0,0,1,1000,0,4,0,0, 1, 0,0,0,0);
        push(0,0,1,1000,0,4,0,0, 1, 4000,4000,1,0);
        // Quarter-rate LO, then full-scale negative DC
        push(1,0,0,0,0,4,1,0);
        push(0,0,1,100,1<<22,4,1,0);
        push(0,0,1,100,1<<22,4,1,0);
        push(0,0,1,-100,1<<22,4,1,0);
        push(0,0,1,-100,1<<22,4,1,0, 1, 400,0,1,0);
        push(0,0,1,-32768,1<<22,4,1,0, 1, 400,0,0,0);
        push(0,0,1,-32768,1<<22,4,1,0);
        push(0,0,1,-32768,1<<22,4,1,0);
        push(0,0,1,-32768,1<<22,4,1,0, 1, 0,0,1,0);
        // Overrun with consumer stalled, then clear
        push(1,0,0,0,0,2,0,0);
        push(0,0,1,10,0,2,0,0);
        push(0,0,1,10,0,2,0,0, 1, 20,20,1,0);
        push(0,0,1,10,0,2,0,0);
        push(0,0,1,10,0,2,0,0, 1, 20,20,1,1);
        push(0,0,0,0,0,2,0,1, 1, 20,20,1,0);
        // Dump coinciding with consumer accept
        push(1,0,0,0,0,1,0,0);
        push(0,0,1,3,0,1,0,0, 1, 3,3,1,0);
        push(0,0,1,4,0,1,1,0, 1, 4,4,1,0);
        // Standby mid-block
        push(1,0,0,0,0,4,1,0);
        push(0,0,1,9,0,4,1,0);
        push(0,0,1,9,0,4,1,0);
        push(0,1,1,9,0,4,1,0);
        push(0,0,1,5,0,4,1,0);
        push(0,0,1,5,0,4,1,0);
        push(0,0,1,5,0,4,1,0, 1, 0,0,0,0);
        push(0,0,1,5,0,4,1,0, 1, 20,20,1,0);
        // Reset mid-block
        push(1,0,0,0,0,4,1,0);
        push(0,0,1,9,0,4,1,0);
        push(0,0,1,9,0,4,1,0);
        push(1,0,1,9,0,4,1,0, 1, 0,0,0,0);
        push(0,0,1,5,0,4,1,0);
        push(0,0,1,5,0,4,1,0);
        push(0,0,1,5,0,4,1,0, 1, 0,0,0,0);
        push(0,0,1,5,0,4,1,0, 1, 20,20,1,0);

        #1;
        foreach (tbl[k]) begin
            rst = tbl[k].rst; stdby = tbl[k].stdby; adc_valid = tbl[k].av;
            adc_data = DBITS'(tbl[k].data); lo_freq = NBITS'(tbl[k].lo);
            decim = 16'(tbl[k].dec); out_ready = tbl[k].rdy; overrun_clr = tbl[k].clr;
            step();
            $display("vec %0d: i=%0d q=%0d v=%0b o=%0b", k, i_out, q_out, out_valid, overrun);
            if (tbl[k].chk) begin
                total++;
                if (longint'(i_out) != tbl[k].ei || longint'(q_out) != tbl[k].eq ||
                    out_valid != tbl[k].ev || overrun != tbl[k].eo) begin
                    bad++;
                    $display("FAIL vec%0d: got i=%0d q=%0d v=%0b o=%0b want i=%0d q=%0d v=%0b o=%0b",
                             k, i_out, q_out, out_valid, overrun,
                             tbl[k].ei, tbl[k].eq, tbl[k].ev, tbl[k].eo);
                end
            end
        end

        // Randomized traffic, including decim changes mid-block
        decim = 16'($urandom_range(0, 5));
        for (int n = 0; n < 2000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stdby       = ($urandom_range(0, 9) == 0);
            adc_valid   = ($urandom_range(0, 3) != 0);
            adc_data    = DBITS'($urandom);
            if ($urandom_range(0, 15) == 0) lo_freq = NBITS'($urandom);
            if ($urandom_range(0, 7) == 0) decim = 16'($urandom_range(0, 5));
            out_ready   = $urandom_range(0, 1) == 1;
            overrun_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssb_demodulator.md
# ssb_demodulator

Receive-side counterpart of the SSB modulator: takes signed ADC samples from the loop-antenna front end and mixes them with a numerically controlled square-wave local oscillator (LO) in quadrature. It integrates and dumps the I and Q products over a programmable number of samples. The decimated I/Q pair is delivered to the downstream audio/DSP path over a valid/ready handshake.

## Interface
- NBITS, 24, LO phase accumulator width; f_LO = f_s * lo_freq / 2**NBITS, where f_s is the adc_valid rate
- DBITS, 16, ADC sample width (two's complement)
- ACCW, DBITS+17, integrator and output width; no overflow for any decim ≤ 65535
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stdby  in  1  standby: samples ignored, integrators cleared
- adc_data  in  DBITS  signed sample, qualified by adc_valid
- adc_valid  in  1  one sample per cycle when high
- lo_freq  in  NBITS  LO phase increment per sample
- decim  in  16  samples per output; values 0 and 1 both mean 1
- i_out  out  ACCW  signed in-phase sum
- q_out  out  ACCW  signed quadrature sum
- out_valid  out  1  i_out/q_out hold a result
- out_ready  in  1  consumer accepts the result
- overrun  out  1  sticky: a result was discarded
- overrun_clr  in  1  clears overrun

## Operation
- Phase accumulator `phase[NBITS-1:0]`: on each accepted sample, `phase <= phase + lo_freq`, wrapping mod 2**NBITS. The mix uses the phase value before the update, so the first sample after reset uses phase 0.
- LO signs:
  - s_i = −1 if phase[NBITS-1], else +1 (sine-like).
  - s_q = −1 if phase[NBITS-1]^phase[NBITS-2], else +1 (cosine-like).
- Products are ±adc_data, sign-extended to ACCW. −2**(DBITS-1) × −1 is exact; no saturation is needed anywhere.
- Accepted sample means adc_valid=1 and stdby=0.
- Per accepted sample:
  - Increment the sample counter `cnt`.
  - Add the products to `i_acc` and `q_acc`.
- Dump on the accepted sample where cnt ≥ max(decim,1)−1. The `≥` compare makes a decim reduction mid-block dump on the next sample.
  - Result = acc + current product.
  - acc ← 0, cnt ← 0.
- Output register and handshake:
  - A dump with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle: load i_out/q_out and set out_valid=1. No overrun.
  - A dump with out_valid=1 and out_ready=0: discard the new result, keep the old i_out/q_out, set overrun=1.
  - out_valid=1, out_ready=1, no dump: clear out_valid. i_out/q_out keep their last values.
- stdby=1:
  - Clear cnt, i_acc and q_acc; hold phase.
  - The output register and handshake keep working normally.
- overrun:
  - overrun_clr=1 clears it on the next edge.
  - If overrun_clr=1 and a new overrun occur in the same cycle, the set wins.
- lo_freq and decim may change at any time and take effect on the next accepted sample. The phase is not reset.

## Timing
- Reset values: phase=0, cnt=0, i_acc=q_acc=0, i_out=q_out=0, out_valid=0, overrun=0.
- Latency: a dump sample accepted at edge t gives out_valid=1 and the new i_out/q_out visible after edge t, one cycle.
- Throughput: one sample per clock. With decim=1 and out_ready held at 1, out_valid stays high continuously and carries a new result every cycle.
- rst mid-block or during a pending output: everything returns to the reset values on that edge and the partial sums are lost.
- adc_valid gaps only stall the block; the decimation count is in samples, not cycles.

## Test plan
- Reset → i_out=q_out=0, out_valid=0, overrun=0. First dump of a DC block after reset uses phase 0 (s_i=s_q=+1).
- lo_freq=0, decim=4, adc_data=1000 constant for 4 samples → i_out=q_out=4000, out_valid high the cycle after the 4th sample.
- lo_freq=2**22 (NBITS=24), decim=4, samples +100,+100,−100,−100 → i_out=400, q_out=0. Repeat with −32768 constant → i_out=q_out=0, no width error.
- out_ready=0, decim=2, 4 samples of 10 → first result 20 held, second discarded, overrun=1. Then overrun_clr pulse → overrun=0.
- Dump coincides with out_ready=1 while out_valid=1 → new result loaded, out_valid stays 1, overrun stays 0.
- stdby=1 after 2 of 4 samples, then stdby=0 and 4 samples of 5 → result 20. Repeat with rst pulsed mid-block → same result, outputs are 0 until the dump.
